// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC decimator.
package cic_pkg;

    // Number of integrator/comb stages in the filter.
    localparam int unsigned CIC_ORDER = 3;

    // Width needed to hold the worst-case filter growth of CIC_ORDER * LOG2R bits.
    function automatic int unsigned cic_out_w(input int unsigned in_w, input int unsigned log2r);
        return in_w + CIC_ORDER * log2r;
    endfunction

endpackage

// File: rtl/cic_comb.sv
// One CIC comb stage: dout = din - din_delayed. The delay updates only on en.
module cic_comb #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] z_q;

    // Difference against the previous decimated input, modulo 2^W.
    assign dout = din - z_q;

    // Delay element, advanced once per decimated sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= '0;
        end else if (en) begin
            z_q <= din;
        end
    end

endmodule

// File: rtl/mash_cic_decimator.sv
// Third-order CIC decimator (sinc^3, R = 2^LOG2R) for a MASH 1-1-1 modulator word.
// Optional build macro CIC_OVF_EN adds a sticky overrun flag output 'ovf'.
module mash_cic_decimator
    import cic_pkg::*;
#(
    parameter  int unsigned LOG2R = 4,
    parameter  int unsigned IN_W  = 4,
    localparam int unsigned OUT_W = cic_out_w(IN_W, LOG2R)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_f,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef CIC_OVF_EN
    ,
    output logic                    ovf
`endif
);

    logic [OUT_W-1:0] in_ext;
    logic [OUT_W-1:0] i1_q, i2_q, i3_q;
    logic [LOG2R-1:0] cnt_q;
    logic             dec_q;
    logic [OUT_W-1:0] c1, c2, c3;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    assign in_ext = {{(OUT_W - IN_W){in_f[IN_W-1]}}, in_f};

    // Pipelined integrators: each stage adds the previous stage's registered value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_q <= '0;
            i2_q <= '0;
            i3_q <= '0;
        end else if (in_valid) begin
            i1_q <= i1_q + in_ext;
            i2_q <= i2_q + i1_q;
            i3_q <= i3_q + i2_q;
        end
    end

    // Sample counter; the strobe fires after the last sample of each block of R.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dec_q <= 1'b0;
        end else begin
            dec_q <= in_valid && (&cnt_q);
            if (in_valid) begin
                cnt_q <= cnt_q + LOG2R'(1);
            end
        end
    end

    cic_comb #(
        .W (OUT_W)
    ) u_comb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dec_q),
        .din   (i3_q),
        .dout  (c1)
    );

    cic_comb #(
        .W (OUT_W)
    ) u_comb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dec_q),
        .din   (c1),
        .dout  (c2)
    );

    cic_comb #(
        .W (OUT_W)
    ) u_comb3 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dec_q),
        .din   (c2),
        .dout  (c3)
    );

    // Output holding register: a new result always wins over a handshake clear.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (dec_q) begin
            out_data_d  = c3;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef CIC_OVF_EN
    logic overrun;
    logic ovf_q;

    // A result replaced before the consumer took it.
    assign overrun = dec_q && out_valid_q && !out_ready;

    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (overrun) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
